bv_cfg_writer: RTL and testbench
================================

// Module: bv_cfg_writer
// PURPOSE
//  Configuration loader for the bit-vector RAM banks: takes a valid/ready word stream from the control
//  plane (header + payload), drives the shared wr_en/sram_sel/addr_wr/din write bus into all banks.
//  Sits between the cfg interconnect and bv_top; writer end of the bank write port.
// PARAMETERS
//  NUM_RAMS   32  banks on the write bus; legal sram_sel 0..NUM_RAMS-1
//  DATA_DEPTH 48  words per bank; legal addr_wr 0..DATA_DEPTH-1
//  DATA_WIDTH 32  payload/din width (fixed 32 by bus)
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   asynchronous reset, active low
//  cfg_valid  in   1   stream word valid
//  cfg_ready  out  1   stream word accepted when valid&ready
//  cfg_data   in   32  header or payload word
//  cfg_last   in   1   final word of burst
//  wr_en      out  1   bank write strobe
//  sram_sel   out  5   target bank index
//  addr_wr    out  6   target word address
//  din        out  32  write data
//  busy       out  1   burst in progress (state != IDLE)
//  done       out  1   1-cycle pulse at burst end
//  err_code   out  3   0 OK,1 BAD_MAGIC,2 BAD_SEL,3 NO_PAYLOAD,4 SHORT,5 LONG,6 ADDR_OOR
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, err_code 0. Reset mid-burst aborts; no partial write emitted after.
//  Header word: [31:24] magic 8'hB5, [16:11] len-1, [10:5] base addr, [4:0] sel.
//  States IDLE -> DATA -> DONE -> IDLE; FLUSH for errors.
//   IDLE : cfg_ready=1. Header accepted: latch sel/base/len, clear err_code, counter=0.
//          bad magic ->err1, sel>=NUM_RAMS ->err2: go FLUSH (or DONE if cfg_last). cfg_last on valid
//          header -> err3, DONE. Else DATA.
//   DATA : cfg_ready=1. Each accepted word -> next cycle wr_en=1, addr_wr=base+counter, din=word,
//          sram_sel=latched sel (1-cycle latency, one write per accepted word, back-to-back allowed).
//          base+counter computed 7-bit; >=DATA_DEPTH -> wr_en suppressed, err6 (sticky, burst continues).
//          Word with counter==len and cfg_last -> DONE. cfg_last with counter<len -> err4, DONE.
//          counter==len without cfg_last -> err5, FLUSH.
//   FLUSH: cfg_ready=1, words dropped, no writes, until cfg_last accepted -> DONE.
//   DONE : cfg_ready=0 for exactly 1 cycle; done=1 this cycle (coincides with last wr_en); -> IDLE.
//  Error precedence when simultaneous: first detected kept (err_code written only while 0).
//  err_code holds until next header accepted. wr_en never asserts outside DATA-originated writes.
//  sram_sel/addr_wr/din hold last value when wr_en=0.
//  Max burst 64 payload words; len field wraps nothing (counter 6-bit, compared before increment).
// STRUCTURE
//  bv_cfg_pkg: header field offsets/widths, BV_CFG_MAGIC, ERR_* codes, state encoding.
//  Sub-module bv_cfg_hdr_dec (combinational header decode + legality checks); rest in one always block
//  FSM plus registered write-bus stage.
// TESTING
//  T1 hdr sel=3 base=0 len-1=3, words A0..A3 last on A3 -> 4 wr_en on consecutive cycles addr 0..3,
//     din A0..A3, done with 4th write, err_code 0.
//  T2 cfg_valid toggling 1/0 during payload -> writes track accepted words only, order/addresses kept.
//  T3 hdr base=46 len-1=3 -> writes at 46,47 only; err_code 6; done after 4th word.
//  T4 hdr magic 8'hA5 then 5 words, last on 5th -> no wr_en, err_code 1, done on 5th.
//  T5 len-1=7 but cfg_last on 3rd payload word -> 3 writes, err_code 4; len-1=1, 4 words -> 2 writes,
//     err_code 5, remaining dropped, done at last.
//  T6 rst_n low mid-DATA -> wr_en/busy/done/err_code 0 immediately; next clean burst completes OK.

Source files
------------

// File: rtl/bv_cfg_pkg.sv
// Shared constants for the bit-vector bank configuration writer: header layout, magic, error codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bv_cfg_pkg;

    localparam int NUM_RAMS   = 32;
    localparam int DATA_DEPTH = 48;
    localparam int DATA_WIDTH = 32;

    localparam int SEL_W  = 5;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 6;

    // Header word field positions
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_LEN_LSB   = 11;
    localparam int HDR_BASE_LSB  = 5;
    localparam int HDR_SEL_LSB   = 0;

    localparam logic [7:0] BV_CFG_MAGIC = 8'hB5;

    typedef enum logic [2:0] {
        ERR_OK         = 3'd0,
        ERR_BAD_MAGIC  = 3'd1,
        ERR_BAD_SEL    = 3'd2,
        ERR_NO_PAYLOAD = 3'd3,
        ERR_SHORT      = 3'd4,
        ERR_LONG       = 3'd5,
        ERR_ADDR_OOR   = 3'd6
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bv_cfg_hdr_dec.sv
// Combinational header decode: splits sel/base/len-1 fields and flags bad magic or out-of-range bank.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the header is consumed.
module bv_cfg_hdr_dec
    import bv_cfg_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] hdr,
    output logic [SEL_W-1:0]      sel,
    output logic [ADDR_W-1:0]     base,
    output logic [LEN_W-1:0]      len_m1,
    output logic [2:0]            hdr_err
);

    localparam logic [SEL_W:0] NUM_RAMS_W = (SEL_W+1)'(NUM_RAMS);

    logic [7:0] magic;
    logic       unused_rsvd;

    assign magic       = hdr[HDR_MAGIC_LSB +: 8];
    assign len_m1      = hdr[HDR_LEN_LSB   +: LEN_W];
    assign base        = hdr[HDR_BASE_LSB  +: ADDR_W];
    assign sel         = hdr[HDR_SEL_LSB   +: SEL_W];
    // Bits between the magic and len fields carry nothing
    assign unused_rsvd = ^hdr[23:17];

    // Magic is checked before the bank index so a garbage word reports as bad magic
    always_comb begin
        hdr_err = ERR_OK;
        if (magic != BV_CFG_MAGIC)
            hdr_err = ERR_BAD_MAGIC;
        else if ({1'b0, sel} >= NUM_RAMS_W)
            hdr_err = ERR_BAD_SEL;
    end

endmodule

// File: rtl/bv_cfg_writer.sv
// Config stream loader: header + payload words become bank writes on the shared wr_en/sram_sel/addr_wr/din bus.
// Latency: one cycle from an accepted payload word to its wr_en strobe; back-to-back words give back-to-back writes.
// Backpressure: cfg_ready is high except for the single DONE cycle that closes each burst.
module bv_cfg_writer
    import bv_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  cfg_last,
    output logic                  wr_en,
    output logic [SEL_W-1:0]      sram_sel,
    output logic [ADDR_W-1:0]     addr_wr,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            err_code
);

    state_e            state, state_nx;
    logic [2:0]        err_nx;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;

    logic [SEL_W-1:0]  hdr_sel;
    logic [ADDR_W-1:0] hdr_base;
    logic [LEN_W-1:0]  hdr_len;
    logic [2:0]        hdr_err;

    logic              accept;
    logic [ADDR_W:0]   wr_addr;
    logic              addr_oor;
    logic              cnt_at_len;

    bv_cfg_hdr_dec u_hdr_dec (
        .hdr     (cfg_data),
        .sel     (hdr_sel),
        .base    (hdr_base),
        .len_m1  (hdr_len),
        .hdr_err (hdr_err)
    );

    assign accept     = cfg_valid & cfg_ready;
    // One extra bit so base+counter past the bank end is caught rather than wrapped
    assign wr_addr    = {1'b0, base_q} + {1'b0, cnt_q};
    assign addr_oor   = wr_addr >= (ADDR_W+1)'(DATA_DEPTH);
    assign cnt_at_len = (cnt_q == len_q);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    // Next state and next error code; an existing nonzero error is never overwritten mid-burst
    always_comb begin
        state_nx = state;
        err_nx   = err_code;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_err != ERR_OK) begin
                        err_nx   = hdr_err;
                        state_nx = cfg_last ? ST_DONE : ST_FLUSH;
                    end else if (cfg_last) begin
                        err_nx   = ERR_NO_PAYLOAD;
                        state_nx = ST_DONE;
                    end else begin
                        err_nx   = ERR_OK;
                        state_nx = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (cnt_at_len)
                        state_nx = cfg_last ? ST_DONE : ST_FLUSH;
                    else if (cfg_last)
                        state_nx = ST_DONE;
                    if (err_code == ERR_OK) begin
                        if (addr_oor)
                            err_nx = ERR_ADDR_OOR;
                        else if (cnt_at_len && !cfg_last)
                            err_nx = ERR_LONG;
                        else if (!cnt_at_len && cfg_last)
                            err_nx = ERR_SHORT;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept && cfg_last)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, header latches, payload counter and the registered write-bus stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b0;
            err_code  <= ERR_OK;
            sel_q     <= '0;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wr_en     <= 1'b0;
            sram_sel  <= '0;
            addr_wr   <= '0;
            din       <= '0;
        end else begin
            state     <= state_nx;
            cfg_ready <= (state_nx != ST_DONE);
            err_code  <= err_nx;
            wr_en     <= 1'b0;
            if (state == ST_IDLE && accept) begin
                sel_q  <= hdr_sel;
                base_q <= hdr_base;
                len_q  <= hdr_len;
                cnt_q  <= '0;
            end else if (state == ST_DATA && accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Out-of-range words are swallowed; the bus keeps its previous address/data
            if (state == ST_DATA && accept && !addr_oor) begin
                wr_en    <= 1'b1;
                sram_sel <= sel_q;
                addr_wr  <= wr_addr[ADDR_W-1:0];
                din      <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_bv_cfg_writer.sv
// Directed bench for bv_cfg_writer: hand-computed write logs, error codes and done timing per burst.
// Latency: n/a.
// Backpressure: honours cfg_ready before each word.
module tb_bv_cfg_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic        wr_en;
    logic [4:0]  sram_sel;
    logic [5:0]  addr_wr;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [2:0]  err_code;

    int errors = 0;
    int checks = 0;

    // Write/done log captured by the monitor
    int          cyc = 0;
    logic [5:0]  log_addr[$];
    logic [4:0]  log_sel[$];
    logic [31:0] log_din[$];
    int          log_cyc[$];
    int          done_cnt = 0;
    logic        done_with_wr = 1'b0;

    bv_cfg_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .wr_en     (wr_en),
        .sram_sel  (sram_sel),
        .addr_wr   (addr_wr),
        .din       (din),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Sample the write bus mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                log_addr.push_back(addr_wr);
                log_sel.push_back(sram_sel);
                log_din.push_back(din);
                log_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_with_wr = wr_en;
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] magic, input logic [5:0] lenm1,
                                        input logic [5:0] base, input logic [4:0] sel);
        return {magic, 7'b0, lenm1, base, sel};
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_sel.delete();
        log_din.delete();
        log_cyc.delete();
        done_cnt     = 0;
        done_with_wr = 1'b0;
    endtask

    // Present one word and hold it until the DUT takes it
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n         = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        @(negedge clk);
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        idle(3);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_code), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_bus", {sram_sel, addr_wr, 21'b0}, 0);
        chk("rst_din", din, 0);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_ready", 32'(cfg_ready), 1);

        // T1: four back-to-back words into bank 3 from address 0
        clear_log();
        send(hdr(8'hB5, 6'd3, 6'd0, 5'd3), 1'b0);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), (i == 3));
        wait_done("t1");
        chk("t1_nwr", 32'(log_addr.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), 32'(log_addr[i]), 32'(i));
            chk($sformatf("t1_din%0d", i), log_din[i], 32'hA0 + 32'(i));
            chk($sformatf("t1_sel%0d", i), 32'(log_sel[i]), 3);
            chk($sformatf("t1_cyc%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
        end
        chk("t1_done_cnt", 32'(done_cnt), 1);
        chk("t1_done_with_wr", 32'(done_with_wr), 1);
        chk("t1_err", 32'(err_code), 0);
        chk("t1_idle", 32'(busy), 0);
        // sram_sel/addr_wr/din hold their last written value
        chk("t1_hold", {sram_sel, addr_wr, 21'b0}, {5'd3, 6'd3, 21'b0});

        // T2: gaps between payload words
        clear_log();
        send(hdr(8'hB5, 6'd3, 6'd10, 5'd5), 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(32'hB0 + 32'(i), (i == 3));
            if (i != 3) idle(1);
        end
        wait_done("t2");
        chk("t2_nwr", 32'(log_addr.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_addr%0d", i), 32'(log_addr[i]), 32'(10 + i));
            chk($sformatf("t2_din%0d", i), log_din[i], 32'hB0 + 32'(i));
        end
        chk("t2_gap", 32'(log_cyc[1] - log_cyc[0]), 2);
        chk("t2_err", 32'(err_code), 0);

        // T3: base 46 runs off the end of the bank
        clear_log();
        send(hdr(8'hB5, 6'd3, 6'd46, 5'd7), 1'b0);
        for (int i = 0; i < 4; i++) send(32'hC0 + 32'(i), (i == 3));
        wait_done("t3");
        chk("t3_nwr", 32'(log_addr.size()), 2);
        chk("t3_addr0", 32'(log_addr[0]), 46);
        chk("t3_addr1", 32'(log_addr[1]), 47);
        chk("t3_din1", log_din[1], 32'hC1);
        chk("t3_sel0", 32'(log_sel[0]), 7);
        chk("t3_err", 32'(err_code), 6);
        chk("t3_done_with_wr", 32'(done_with_wr), 0);
        chk("t3_done_cnt", 32'(done_cnt), 1);

        // T4: bad magic, five words flushed
        clear_log();
        send(hdr(8'hA5, 6'd3, 6'd0, 5'd1), 1'b0);
        for (int i = 0; i < 4; i++) send(32'hD0 + 32'(i), 1'b0);
        idle(1);
        chk("t4_no_early_done", 32'(done_cnt), 0);
        chk("t4_busy", 32'(busy), 1);
        send(32'hD4, 1'b1);
        wait_done("t4");
        chk("t4_nwr", 32'(log_addr.size()), 0);
        chk("t4_err", 32'(err_code), 1);
        chk("t4_done_cnt", 32'(done_cnt), 1);

        // T5a: burst cut short
        clear_log();
        send(hdr(8'hB5, 6'd7, 6'd0, 5'd1), 1'b0);
        for (int i = 0; i < 3; i++) send(32'hE0 + 32'(i), (i == 2));
        wait_done("t5a");
        chk("t5a_nwr", 32'(log_addr.size()), 3);
        chk("t5a_addr2", 32'(log_addr[2]), 2);
        chk("t5a_err", 32'(err_code), 4);
        chk("t5a_done_with_wr", 32'(done_with_wr), 1);

        // T5b: burst too long, excess dropped
        clear_log();
        send(hdr(8'hB5, 6'd1, 6'd20, 5'd2), 1'b0);
        for (int i = 0; i < 3; i++) send(32'hF0 + 32'(i), 1'b0);
        idle(1);
        chk("t5b_no_early_done", 32'(done_cnt), 0);
        send(32'hF3, 1'b1);
        wait_done("t5b");
        chk("t5b_nwr", 32'(log_addr.size()), 2);
        chk("t5b_addr0", 32'(log_addr[0]), 20);
        chk("t5b_addr1", 32'(log_addr[1]), 21);
        chk("t5b_din1", log_din[1], 32'hF1);
        chk("t5b_err", 32'(err_code), 5);
        chk("t5b_done_cnt", 32'(done_cnt), 1);

        // Header carrying cfg_last: no payload
        clear_log();
        send(hdr(8'hB5, 6'd3, 6'd0, 5'd4), 1'b1);
        wait_done("nopay");
        chk("nopay_nwr", 32'(log_addr.size()), 0);
        chk("nopay_err", 32'(err_code), 3);

        // T6: reset in the middle of a burst
        clear_log();
        send(hdr(8'hB5, 6'd7, 6'd0, 5'd4), 1'b0);
        send(32'h11, 1'b0);
        send(32'h12, 1'b0);
        chk("t6_pre_wr_en", 32'(wr_en), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(wr_en), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_done", 32'(done), 0);
        chk("t6_rst_err", 32'(err_code), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        idle(3);
        chk("t6_no_partial", 32'(log_addr.size()), 0);
        send(hdr(8'hB5, 6'd1, 6'd5, 5'd9), 1'b0);
        send(32'h21, 1'b0);
        send(32'h22, 1'b1);
        wait_done("t6");
        chk("t6_nwr", 32'(log_addr.size()), 2);
        chk("t6_addr0", 32'(log_addr[0]), 5);
        chk("t6_addr1", 32'(log_addr[1]), 6);
        chk("t6_din1", log_din[1], 32'h22);
        chk("t6_sel1", 32'(log_sel[1]), 9);
        chk("t6_err", 32'(err_code), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
